// File: rtl/lstm_dma_sequencer.sv
// Sequences one LSTM step over the main-memory DMA engine: optional weight load, feature load,
// compute handshake, result write-back. All outputs are registered from the next-state logic.
module lstm_dma_sequencer #(
  parameter int unsigned MAIN_MEM_ADD_LEN = 11,
  parameter int unsigned FEATURES         = 4,
  parameter int unsigned WEIGHTS          = 64,
  parameter int unsigned OUTPUTS          = 4
) (
  input  logic                        fpga_clk,
  input  logic                        reset_n,
  input  logic                        go,
  input  logic                        load_weights,
  input  logic                        abort,
  input  logic [MAIN_MEM_ADD_LEN-1:0] feat_base,
  input  logic [MAIN_MEM_ADD_LEN-1:0] wgt_base,
  input  logic [MAIN_MEM_ADD_LEN-1:0] out_base,
  input  logic                        lstm_done,
  output logic                        dmac_direct,
  output logic                        dmac_start,
  output logic [MAIN_MEM_ADD_LEN-1:0] dmac_count,
  output logic [MAIN_MEM_ADD_LEN-1:0] dmac_first_address,
  output logic [1:0]                  lstm_dest,
  output logic [MAIN_MEM_ADD_LEN-1:0] lstm_wr_idx,
  output logic                        lstm_start,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned AW = MAIN_MEM_ADD_LEN;

  if (FEATURES < 1 || WEIGHTS < 1 || OUTPUTS < 1 ||
      longint'(FEATURES) >= (longint'(1) << AW) ||
      longint'(WEIGHTS) >= (longint'(1) << AW) ||
      longint'(OUTPUTS) >= (longint'(1) << AW)) begin : g_bad_count
    $error("lstm_dma_sequencer: phase counts must be in 1..2^MAIN_MEM_ADD_LEN-1");
  end

  localparam logic [AW-1:0] FeatN    = AW'(FEATURES);
  localparam logic [AW-1:0] WgtN     = AW'(WEIGHTS);
  localparam logic [AW-1:0] OutN     = AW'(OUTPUTS);
  localparam logic [AW-1:0] FeatLast = AW'(FEATURES - 1);
  localparam logic [AW-1:0] WgtLast  = AW'(WEIGHTS - 1);
  localparam logic [AW-1:0] OutLast  = AW'(OUTPUTS - 1);

  localparam logic [1:0] DestNone = 2'b00;
  localparam logic [1:0] DestFeat = 2'b01;
  localparam logic [1:0] DestWgt  = 2'b10;

  typedef enum logic [3:0] {
    StIdle, StWStart, StWRun, StFStart, StFRun, StCStart, StCWait,
    StSStart, StSRun, StSDrain, StDone, StAbortDrain
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  // One bit wider: an abort in S_START must drain OUTPUTS+1 cycles.
  logic [AW:0]     drain_q, drain_d;
  logic [AW-1:0]   feat_base_q, feat_base_d;
  logic [AW-1:0]   wgt_base_q, wgt_base_d;
  logic [AW-1:0]   out_base_q, out_base_d;

  logic            dmac_direct_q, dmac_direct_d;
  logic            dmac_start_q, dmac_start_d;
  logic [AW-1:0]   dmac_count_q, dmac_count_d;
  logic [AW-1:0]   dmac_addr_q, dmac_addr_d;
  logic [1:0]      lstm_dest_q, lstm_dest_d;
  logic [AW-1:0]   lstm_wr_idx_q, lstm_wr_idx_d;
  logic            lstm_start_q, lstm_start_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [AW:0]     rem;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    drain_d     = drain_q;
    feat_base_d = feat_base_q;
    wgt_base_d  = wgt_base_q;
    out_base_d  = out_base_q;
    rem         = '0;

    unique case (state_q)
      StIdle: begin
        if (go) begin
          feat_base_d = feat_base;
          wgt_base_d  = wgt_base;
          out_base_d  = out_base;
          state_d     = load_weights ? StWStart : StFStart;
        end
      end
      StWStart: begin
        cnt_d   = '0;
        state_d = StWRun;
      end
      StWRun: begin
        if (cnt_q == WgtLast) state_d = StFStart;
        else                  cnt_d   = cnt_q + 1'b1;
      end
      StFStart: begin
        cnt_d   = '0;
        state_d = StFRun;
      end
      StFRun: begin
        if (cnt_q == FeatLast) state_d = StCStart;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      StCStart: state_d = StCWait;
      StCWait: begin
        if (lstm_done) state_d = StSStart;
      end
      StSStart: begin
        cnt_d   = '0;
        state_d = StSRun;
      end
      StSRun: begin
        if (cnt_q == OutLast) state_d = StSDrain;
        else                  cnt_d   = cnt_q + 1'b1;
      end
      StSDrain: state_d = StDone;
      StDone:   state_d = StIdle;
      StAbortDrain: begin
        if (drain_q <= (AW+1)'(1)) state_d = StIdle;
        else                       drain_d = drain_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // Abort: let the engine finish the transfer it already owns, then go idle.
    if (abort && state_q != StIdle && state_q != StAbortDrain) begin
      unique case (state_q)
        StWStart: rem = {1'b0, WgtN};
        StFStart: rem = {1'b0, FeatN};
        StSStart: rem = {1'b0, OutN} + 1'b1;
        StWRun:   rem = {1'b0, WgtLast - cnt_q};
        StFRun:   rem = {1'b0, FeatLast - cnt_q};
        StSRun:   rem = {1'b0, OutN - cnt_q};
        default:  rem = '0;
      endcase
      if (rem == '0) begin
        state_d = StIdle;
      end else begin
        state_d = StAbortDrain;
        drain_d = rem;
      end
    end
  end

  always_comb begin
    dmac_direct_d = dmac_direct_q;
    dmac_count_d  = dmac_count_q;
    dmac_addr_d   = dmac_addr_q;
    unique case (state_d)
      StWStart: begin
        dmac_direct_d = 1'b0;
        dmac_count_d  = WgtN;
        dmac_addr_d   = wgt_base_d;
      end
      StFStart: begin
        dmac_direct_d = 1'b0;
        dmac_count_d  = FeatN;
        dmac_addr_d   = feat_base_d;
      end
      StSStart: begin
        dmac_direct_d = 1'b1;
        dmac_count_d  = OutN;
        dmac_addr_d   = out_base_d;
      end
      default: ;
    endcase

    dmac_start_d  = (state_d == StWStart) || (state_d == StFStart) || (state_d == StSStart);
    lstm_dest_d   = (state_d == StWRun) ? DestWgt :
                    (state_d == StFRun) ? DestFeat : DestNone;
    lstm_wr_idx_d = (state_d == StWRun || state_d == StFRun) ? cnt_d : '0;
    lstm_start_d  = (state_d == StCStart);
    busy_d        = (state_d != StIdle);
    done_d        = (state_d == StDone);
  end

  always_ff @(posedge fpga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      drain_q       <= '0;
      feat_base_q   <= '0;
      wgt_base_q    <= '0;
      out_base_q    <= '0;
      dmac_direct_q <= 1'b0;
      dmac_start_q  <= 1'b0;
      dmac_count_q  <= '0;
      dmac_addr_q   <= '0;
      lstm_dest_q   <= DestNone;
      lstm_wr_idx_q <= '0;
      lstm_start_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      drain_q       <= drain_d;
      feat_base_q   <= feat_base_d;
      wgt_base_q    <= wgt_base_d;
      out_base_q    <= out_base_d;
      dmac_direct_q <= dmac_direct_d;
      dmac_start_q  <= dmac_start_d;
      dmac_count_q  <= dmac_count_d;
      dmac_addr_q   <= dmac_addr_d;
      lstm_dest_q   <= lstm_dest_d;
      lstm_wr_idx_q <= lstm_wr_idx_d;
      lstm_start_q  <= lstm_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign dmac_direct        = dmac_direct_q;
  assign dmac_start         = dmac_start_q;
  assign dmac_count         = dmac_count_q;
  assign dmac_first_address = dmac_addr_q;
  assign lstm_dest          = lstm_dest_q;
  assign lstm_wr_idx        = lstm_wr_idx_q;
  assign lstm_start         = lstm_start_q;
  assign busy               = busy_q;
  assign done               = done_q;

endmodule

// File: tb/tb_lstm_dma_sequencer.sv
// Directed bench for lstm_dma_sequencer: transfer descriptors are queued when a step is launched
// and popped on each dmac_start; read-data tagging is checked cycle by cycle against a window model.
module tb_lstm_dma_sequencer;

  localparam int unsigned AW       = 11;
  localparam int unsigned FEATURES = 4;
  localparam int unsigned WEIGHTS  = 64;
  localparam int unsigned OUTPUTS  = 4;

  logic          fpga_clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          go = 1'b0;
  logic          load_weights = 1'b0;
  logic          abort = 1'b0;
  logic          lstm_done = 1'b0;
  logic [AW-1:0] feat_base = '0;
  logic [AW-1:0] wgt_base = '0;
  logic [AW-1:0] out_base = '0;
  logic          dmac_direct, dmac_start, lstm_start, busy, done;
  logic [AW-1:0] dmac_count, dmac_first_address, lstm_wr_idx;
  logic [1:0]    lstm_dest;

  lstm_dma_sequencer #(
    .MAIN_MEM_ADD_LEN(AW),
    .FEATURES(FEATURES),
    .WEIGHTS(WEIGHTS),
    .OUTPUTS(OUTPUTS)
  ) dut (
    .fpga_clk(fpga_clk),
    .reset_n(reset_n),
    .go(go),
    .load_weights(load_weights),
    .abort(abort),
    .feat_base(feat_base),
    .wgt_base(wgt_base),
    .out_base(out_base),
    .lstm_done(lstm_done),
    .dmac_direct(dmac_direct),
    .dmac_start(dmac_start),
    .dmac_count(dmac_count),
    .dmac_first_address(dmac_first_address),
    .lstm_dest(lstm_dest),
    .lstm_wr_idx(lstm_wr_idx),
    .lstm_start(lstm_start),
    .busy(busy),
    .done(done)
  );

  always #5 fpga_clk = ~fpga_clk;

  typedef struct {
    logic          dir;
    logic [AW-1:0] cnt;
    logic [AW-1:0] addr;
    logic [1:0]    code;
  } xfer_t;

  xfer_t         exp_q[$];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            win_k = 0;
  int            win_n = 0;
  logic [1:0]    win_code = 2'b00;
  logic [AW-1:0] win_cnt = '0;
  logic [AW-1:0] win_addr = '0;
  int            lstm_start_cyc = -1000;
  int            s_cyc = -1000;
  int            resp_cnt = 0;
  int            done_cnt = 0;
  bit            done_seen = 0;
  logic          inj_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctrl"}, 32'({dmac_direct, dmac_start, lstm_dest, lstm_start, busy, done}), 0);
    chk({tag, "_count"}, 32'(dmac_count), 0);
    chk({tag, "_addr"}, 32'(dmac_first_address), 0);
    chk({tag, "_idx"}, 32'(lstm_wr_idx), 0);
  endtask

  // One clock: inputs are taken at the rising edge, outputs checked at the falling edge.
  task automatic tick();
    logic  abort_in, busy_in;
    xfer_t it;
    abort_in = abort;
    busy_in  = busy;
    @(posedge fpga_clk);
    #1;
    cyc++;
    if (resp_cnt > 0) begin
      resp_cnt--;
      lstm_done = inj_done | (resp_cnt == 0);
    end else begin
      lstm_done = inj_done;
    end
    @(negedge fpga_clk);
    done_seen = 0;
    if (reset_n) begin
      if (abort_in && busy_in) begin
        exp_q.delete();
        win_n = 0;
        win_k = 0;
      end
      chk("lstm_dest", 32'(lstm_dest), 32'((win_k < win_n) ? win_code : 2'b00));
      if (win_k < win_n) begin
        chk("lstm_wr_idx", 32'(lstm_wr_idx), 32'(win_k));
        chk("held_count", 32'(dmac_count), 32'(win_cnt));
        chk("held_addr", 32'(dmac_first_address), 32'(win_addr));
        win_k++;
      end
      if (dmac_start) begin
        chk("xfer_pending", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          it = exp_q.pop_front();
          chk("dmac_direct", 32'(dmac_direct), 32'(it.dir));
          chk("dmac_count", 32'(dmac_count), 32'(it.cnt));
          chk("dmac_first_address", 32'(dmac_first_address), 32'(it.addr));
          if (it.dir) begin
            chk("s_start_after_lstm_start", 32'(cyc - lstm_start_cyc), 6);
            s_cyc = cyc;
          end else begin
            win_code = it.code;
            win_cnt  = it.cnt;
            win_addr = it.addr;
            win_k    = 0;
            win_n    = int'(it.cnt);
          end
        end
      end
      if (lstm_start) begin
        lstm_start_cyc = cyc;
        resp_cnt       = 5;
      end
      if (done) begin
        done_cnt++;
        done_seen = 1;
        chk("done_after_s_start", 32'(cyc - s_cyc), OUTPUTS + 2);
      end
    end
  endtask

  task automatic start_step(input logic lw, input logic [AW-1:0] fb, input logic [AW-1:0] wb,
                            input logic [AW-1:0] ob);
    if (lw) exp_q.push_back(xfer_t'{1'b0, AW'(WEIGHTS), wb, 2'b10});
    exp_q.push_back(xfer_t'{1'b0, AW'(FEATURES), fb, 2'b01});
    exp_q.push_back(xfer_t'{1'b1, AW'(OUTPUTS), ob, 2'b00});
    load_weights = lw;
    feat_base    = fb;
    wgt_base     = wb;
    out_base     = ob;
    go           = 1'b1;
    tick();
    go           = 1'b0;
    load_weights = 1'b0;
    chk("busy_after_go", 32'(busy), 1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done_seen && n < 500) begin
      tick();
      n++;
    end
    chk("done_within_bound", 32'(done_seen), 1);
    tick();
    chk("busy_after_done", 32'(busy), 0);
    chk("queue_drained", 32'(exp_q.size()), 0);
  endtask

  task automatic wait_dest(input logic [1:0] code, input int idx);
    int n;
    n = 0;
    while (!(lstm_dest == code && int'(lstm_wr_idx) == idx) && n < 300) begin
      tick();
      n++;
    end
    chk("reach_dest", 32'(lstm_dest == code && int'(lstm_wr_idx) == idx), 1);
  endtask

  initial begin
    int n;
    #2 reset_n = 1'b0;
    #1 check_zero("reset");
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check_zero("idle");

    // Full step with weights.
    start_step(1'b1, 11'h040, 11'h100, 11'h200);
    wait_done();
    chk("done_count_1", 32'(done_cnt), 1);

    // Features only: any weight tag or extra start is flagged by the monitor.
    start_step(1'b0, 11'h123, 11'h7ff, 11'h456);
    wait_done();
    chk("done_count_2", 32'(done_cnt), 2);

    // go during W_RUN and an early lstm_done during F_RUN must both be ignored.
    start_step(1'b1, 11'h010, 11'h300, 11'h050);
    wait_dest(2'b10, 5);
    go = 1'b1;
    load_weights = 1'b0;
    tick();
    go = 1'b0;
    wait_dest(2'b01, 0);
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    wait_done();
    chk("done_count_3", 32'(done_cnt), 3);

    // Abort on the 10th weight word: drain the rest, no done.
    start_step(1'b1, 11'h020, 11'h400, 11'h060);
    wait_dest(2'b10, 9);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n = 1;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk("abort_busy_cycles", 32'(n), 55);
    tick();
    tick();
    chk("done_count_abort", 32'(done_cnt), 3);
    start_step(1'b0, 11'h0a0, 11'h000, 11'h0b0);
    wait_done();
    chk("done_count_4", 32'(done_cnt), 4);

    // Asynchronous reset while waiting on the core.
    start_step(1'b1, 11'h040, 11'h100, 11'h200);
    n = 0;
    while (!lstm_start && n < 300) begin
      tick();
      n++;
    end
    chk("saw_lstm_start", 32'(lstm_start), 1);
    tick();
    tick();
    reset_n = 1'b0;
    #1 check_zero("midreset");
    exp_q.delete();
    win_n    = 0;
    win_k    = 0;
    resp_cnt = 0;
    tick();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    start_step(1'b1, 11'h040, 11'h100, 11'h200);
    wait_done();
    chk("done_count_5", 32'(done_cnt), 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
